// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the decode stage.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface decode_stage_if;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_clk_en;

    logic [31:0] o_pc;
    logic [31:0] o_pc_next;
    logic [31:0] o_instr;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_rd;
    logic [31:0] o_imm;
    logic        o_is_compressed;
    logic        o_illegal;
    logic        o_clk_en;

    modport master (
        output i_pc, i_instr, i_clk_en,
        input  o_pc, o_pc_next, o_instr, o_opcode, o_funct3, o_funct7,
               o_rs1, o_rs2, o_rd, o_imm, o_is_compressed, o_illegal, o_clk_en
    );

    modport slave (
        input  i_pc, i_instr, i_clk_en,
        output o_pc, o_pc_next, o_instr, o_opcode, o_funct3, o_funct7,
               o_rs1, o_rs2, o_rd, o_imm, o_is_compressed, o_illegal, o_clk_en
    );
endinterface

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers the fetched PC/instruction, expands the
// supported RV32C subset and presents decoded fields to the execute stage.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          stall,
    input  logic          flush,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    logic [15:0] c;
    logic        in_comp;
    logic [4:0]  c_rd;
    logic [4:0]  c_rs2;
    logic [4:0]  c_rdp;
    logic [4:0]  c_rs1p;
    logic [11:0] c_imm6;
    logic [11:0] c_lw_off;
    logic [20:0] c_j_off;
    logic [12:0] c_b_off;

    logic [31:0] rvc_instr;
    logic        rvc_illegal;
    logic [31:0] dec_instr;
    logic        dec_illegal;
    logic [XLEN-1:0] dec_pc_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next_q;
    logic [31:0]     instr_q;
    logic            comp_q;
    logic            illegal_q;
    logic            en_q;

    imm_sel_e    imm_sel;
    logic [31:0] imm;

    // Compressed operand fields; primed registers map onto x8..x15.
    assign c        = bus.i_instr[15:0];
    assign in_comp  = (c[1:0] != 2'b11);
    assign c_rd     = c[11:7];
    assign c_rs2    = c[6:2];
    assign c_rdp    = {2'b01, c[4:2]};
    assign c_rs1p   = {2'b01, c[9:7]};
    assign c_imm6   = {{6{c[12]}}, c[12], c[6:2]};
    assign c_lw_off = {5'b0, c[5], c[12:10], c[6], 2'b00};
    assign c_j_off  = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign c_b_off  = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    always_comb begin
        rvc_instr   = '0;
        rvc_illegal = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_010: rvc_instr = {c_lw_off, c_rs1p, 3'b010, c_rdp, OP_LOAD};
            5'b00_110: rvc_instr = {c_lw_off[11:5], c_rdp, c_rs1p, 3'b010,
                                    c_lw_off[4:0], OP_STORE};
            5'b01_000: rvc_instr = {c_imm6, c_rd, 3'b000, c_rd, OP_IMM};
            5'b01_001: rvc_instr = {c_j_off[20], c_j_off[10:1], c_j_off[11],
                                    c_j_off[19:12], 5'd1, OP_JAL};
            5'b01_010: rvc_instr = {c_imm6, 5'd0, 3'b000, c_rd, OP_IMM};
            5'b01_011: begin
                // rd=2 is C.ADDI16SP, which is outside the supported subset.
                if (c_rd == 5'd0 || c_rd == 5'd2 || c_imm6[5:0] == 6'd0)
                    rvc_illegal = 1'b1;
                else
                    rvc_instr = {{8{c[12]}}, c_imm6, c_rd, OP_LUI};
            end
            5'b01_101: rvc_instr = {c_j_off[20], c_j_off[10:1], c_j_off[11],
                                    c_j_off[19:12], 5'd0, OP_JAL};
            5'b01_110: rvc_instr = {c_b_off[12], c_b_off[10:5], 5'd0, c_rs1p, 3'b000,
                                    c_b_off[4:1], c_b_off[11], OP_BRANCH};
            5'b01_111: rvc_instr = {c_b_off[12], c_b_off[10:5], 5'd0, c_rs1p, 3'b001,
                                    c_b_off[4:1], c_b_off[11], OP_BRANCH};
            5'b10_100: begin
                if (c[12] == 1'b0) begin
                    if (c_rs2 != 5'd0)
                        rvc_instr = {7'b0, c_rs2, 5'd0, 3'b000, c_rd, OP_OP};
                    else if (c_rd != 5'd0)
                        rvc_instr = {12'b0, c_rd, 3'b000, 5'd0, OP_JALR};
                    else
                        rvc_illegal = 1'b1;
                end else begin
                    if (c_rs2 != 5'd0)
                        rvc_instr = {7'b0, c_rs2, c_rd, 3'b000, c_rd, OP_OP};
                    else if (c_rd != 5'd0)
                        rvc_instr = {12'b0, c_rd, 3'b000, 5'd1, OP_JALR};
                    else
                        rvc_illegal = 1'b1;  // C.EBREAK is not supported
                end
            end
            default: rvc_illegal = 1'b1;
        endcase
        if (!RVC_EN)
            rvc_illegal = 1'b1;
        if (rvc_illegal)
            rvc_instr = '0;
    end

    always_comb begin
        dec_instr   = bus.i_instr;
        dec_illegal = 1'b0;
        if (in_comp) begin
            dec_instr   = rvc_instr;
            dec_illegal = rvc_illegal;
        end else begin
            case (bus.i_instr[6:0])
                OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: dec_illegal = 1'b0;
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign dec_pc_next = bus.i_pc + (in_comp ? 32'd2 : 32'd4);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= '0;
            pc_next_q <= '0;
            instr_q   <= '0;
            comp_q    <= 1'b0;
            illegal_q <= 1'b0;
            en_q      <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                en_q <= 1'b0;
            end else if (bus.i_clk_en) begin
                pc_q      <= bus.i_pc;
                pc_next_q <= dec_pc_next;
                instr_q   <= dec_instr;
                comp_q    <= in_comp;
                illegal_q <= dec_illegal;
                en_q      <= 1'b1;
            end else begin
                en_q <= 1'b0;
            end
        end
    end

    // Immediate format follows the opcode of the already-expanded instruction.
    always_comb begin
        case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = IMM_I;
            OP_STORE:                 imm_sel = IMM_S;
            OP_BRANCH:                imm_sel = IMM_B;
            OP_LUI, OP_AUIPC:         imm_sel = IMM_U;
            OP_JAL:                   imm_sel = IMM_J;
            default:                  imm_sel = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I: imm = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S: imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B: imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_U: imm = {instr_q[31:12], 12'b0};
            IMM_J: imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign bus.o_pc            = pc_q;
    assign bus.o_pc_next       = pc_next_q;
    assign bus.o_instr         = instr_q;
    assign bus.o_opcode        = instr_q[6:0];
    assign bus.o_funct3        = instr_q[14:12];
    assign bus.o_funct7        = instr_q[31:25];
    assign bus.o_rs1           = instr_q[19:15];
    assign bus.o_rs2           = instr_q[24:20];
    assign bus.o_rd            = instr_q[11:7];
    assign bus.o_imm           = imm;
    assign bus.o_is_compressed = comp_q;
    assign bus.o_illegal       = illegal_q;
    assign bus.o_clk_en        = en_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a semantic RV32I/RVC reference model,
// plus directed literal expectations for the named scenarios.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rstn;
    logic stall;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_on   = 1'b0;

    decode_stage_if bus ();

    decode_stage #(.XLEN(32), .RVC_EN(1'b1)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic        comp;
        logic        ill;
        logic        en;
    } exp_t;

    exp_t m;

    logic [6:0] legal_ops [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                     7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    // {quadrant, funct3} pairs, weighted towards the supported subset
    logic [4:0] cq_tab [0:13] = '{5'b00_010, 5'b00_110, 5'b01_000, 5'b01_001,
                                  5'b01_010, 5'b01_011, 5'b01_101, 5'b01_110,
                                  5'b01_111, 5'b10_100, 5'b10_100, 5'b01_100,
                                  5'b00_000, 5'b10_000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] opc);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3, input logic [6:0] opc);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], opc};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input int val, input int rd);
        logic [31:0] v;
        v = val;
        return {v[31:12], 5'(rd), 7'h37};
    endfunction

    function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        for (int i = 0; i < 11; i++)
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expand a 16-bit word by reading its meaning, then re-encoding in RV32I.
    task automatic model_c(input logic [15:0] c, output logic ill, output logic [31:0] ins);
        int rd, rs2, r42p, rs1p, imm6, uoff, joff, boff;
        rd   = int'(c[11:7]);
        rs2  = int'(c[6:2]);
        r42p = 8 + int'(c[4:2]);
        rs1p = 8 + int'(c[9:7]);
        imm6 = int'(c[6:2]) - (c[12] ? 32 : 0);
        uoff = int'(c[6]) * 4 + int'(c[12:10]) * 8 + int'(c[5]) * 64;
        joff = int'(c[5:3]) * 2 + int'(c[11]) * 16 + int'(c[2]) * 32 + int'(c[7]) * 64
             + int'(c[6]) * 128 + int'(c[10:9]) * 256 + int'(c[8]) * 1024
             - (c[12] ? 2048 : 0);
        boff = int'(c[4:3]) * 2 + int'(c[11:10]) * 8 + int'(c[2]) * 32
             + int'(c[6:5]) * 64 - (c[12] ? 256 : 0);
        ill = 1'b0;
        ins = '0;
        if (c[1:0] == 2'd0 && c[15:13] == 3'd2)      ins = enc_i(uoff, rs1p, 2, r42p, 7'h03);
        else if (c[1:0] == 2'd0 && c[15:13] == 3'd6) ins = enc_s(uoff, r42p, rs1p, 2, 7'h23);
        else if (c[1:0] == 2'd1) begin
            case (c[15:13])
                3'd0: ins = enc_i(imm6, rd, 0, rd, 7'h13);
                3'd1: ins = enc_j(joff, 1);
                3'd2: ins = enc_i(imm6, 0, 0, rd, 7'h13);
                3'd3: if (rd == 0 || rd == 2 || imm6 == 0) ill = 1'b1;
                      else ins = enc_u(imm6 * 4096, rd);
                3'd5: ins = enc_j(joff, 0);
                3'd6: ins = enc_b(boff, 0, rs1p, 0);
                3'd7: ins = enc_b(boff, 0, rs1p, 1);
                default: ill = 1'b1;
            endcase
        end else if (c[1:0] == 2'd2 && c[15:13] == 3'd4) begin
            if (rs2 != 0)     ins = c[12] ? enc_r(rs2, rd, rd) : enc_r(rs2, 0, rd);
            else if (rd != 0) ins = enc_i(0, rd, 0, c[12] ? 1 : 0, 7'h67);
            else              ill = 1'b1;
        end else ill = 1'b1;
        if (ill) ins = '0;
    endtask

    function automatic logic [31:0] imm_of(input logic [31:0] x);
        int v;
        v = 0;
        case (x[6:0])
            7'h03, 7'h13, 7'h67: v = int'(x[30:20]) - (x[31] ? 2048 : 0);
            7'h23: v = int'(x[11:7]) + int'(x[30:25]) * 32 - (x[31] ? 2048 : 0);
            7'h63: v = int'(x[11:8]) * 2 + int'(x[30:25]) * 32 + int'(x[7]) * 2048
                     - (x[31] ? 4096 : 0);
            7'h37, 7'h17: v = int'(x & 32'hFFFF_F000);
            7'h6F: v = int'(x[30:21]) * 2 + int'(x[20]) * 2048 + int'(x[19:12]) * 4096
                     - (x[31] ? (1 << 20) : 0);
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_update(input logic [31:0] pc, input logic [31:0] ins, input logic en,
                                input logic st, input logic fl);
        logic        ill;
        logic [31:0] x;
        if (st) return;
        if (fl || !en) begin
            m.en = 1'b0;
            return;
        end
        m.pc   = pc;
        m.comp = (ins[1:0] != 2'b11);
        m.pc_next = pc + (m.comp ? 32'd2 : 32'd4);
        if (m.comp) begin
            model_c(ins[15:0], ill, x);
        end else begin
            x   = ins;
            ill = !legal_op(ins[6:0]);
        end
        m.instr = x;
        m.ill   = ill;
        m.en    = 1'b1;
    endtask

    task automatic compare_model();
        chk("pc",       bus.o_pc, m.pc);
        chk("pc_next",  bus.o_pc_next, m.pc_next);
        chk("instr",    bus.o_instr, m.instr);
        chk("opcode",   32'(bus.o_opcode), 32'(m.instr[6:0]));
        chk("funct3",   32'(bus.o_funct3), 32'(m.instr[14:12]));
        chk("funct7",   32'(bus.o_funct7), 32'(m.instr[31:25]));
        chk("rs1",      32'(bus.o_rs1), 32'(m.instr[19:15]));
        chk("rs2",      32'(bus.o_rs2), 32'(m.instr[24:20]));
        chk("rd",       32'(bus.o_rd), 32'(m.instr[11:7]));
        chk("imm",      bus.o_imm, imm_of(m.instr));
        chk("comp",     32'(bus.o_is_compressed), 32'(m.comp));
        chk("illegal",  32'(bus.o_illegal), 32'(m.ill));
        chk("clk_en",   32'(bus.o_clk_en), 32'(m.en));
    endtask

    always @(negedge clk) if (cmp_on) compare_model();

    task automatic cycle(input logic [31:0] pc, input logic [31:0] ins, input logic en,
                         input logic st, input logic fl);
        bus.i_pc     = pc;
        bus.i_instr  = ins;
        bus.i_clk_en = en;
        stall        = st;
        flush        = fl;
        @(posedge clk);
        if (rstn) model_update(pc, ins, en, st, fl);
        #1;
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        m = '0;
        chk("rst_clk_en",  32'(bus.o_clk_en), 32'd0);
        chk("rst_pc",      bus.o_pc, 32'd0);
        chk("rst_pc_next", bus.o_pc_next, 32'd0);
        chk("rst_instr",   bus.o_instr, 32'd0);
        chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
        chk("rst_comp",    32'(bus.o_is_compressed), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        logic [4:0]  q;
        int          r;
        w = $urandom();
        r = $urandom_range(0, 9);
        if (r < 4) begin
            w[6:0] = legal_ops[$urandom_range(0, 10)];
        end else if (r == 4) begin
            w[1:0] = 2'b11;
        end else if (r < 9) begin
            q = cq_tab[$urandom_range(0, 13)];
            w[1:0]   = q[4:3];
            w[15:13] = q[2:0];
            if ($urandom_range(0, 5) == 0) w[11:7] = ($urandom_range(0, 1) == 1) ? 5'd2 : 5'd0;
            if ($urandom_range(0, 5) == 0) begin
                w[12]  = 1'b0;
                w[6:2] = 5'd0;
            end
        end
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        logic        st, fl, en;
        rstn = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.i_pc = '0;
        bus.i_instr = '0;
        bus.i_clk_en = 1'b0;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clk_en", 32'(bus.o_clk_en), 32'd0);
        chk("reset_pc",     bus.o_pc, 32'd0);
        chk("reset_instr",  bus.o_instr, 32'd0);
        chk("reset_imm",    bus.o_imm, 32'd0);
        rstn = 1'b1;
        cmp_on = 1'b1;

        cycle(32'h100, 32'h0050_0093, 1, 0, 0);
        chk("t1_rd", 32'(bus.o_rd), 32'd1);
        chk("t1_rs1", 32'(bus.o_rs1), 32'd0);
        chk("t1_imm", bus.o_imm, 32'd5);
        chk("t1_pc_next", bus.o_pc_next, 32'h104);
        chk("t1_clk_en", 32'(bus.o_clk_en), 32'd1);
        chk("t1_comp", 32'(bus.o_is_compressed), 32'd0);

        cycle(32'h102, 32'hABCD_450D, 1, 0, 0);
        chk("t2_instr", bus.o_instr, 32'h0030_0513);
        chk("t2_comp", 32'(bus.o_is_compressed), 32'd1);
        chk("t2_pc_next", bus.o_pc_next, 32'h104);

        cycle(32'h104, 32'hFE20_8CE3, 1, 0, 0);
        chk("t3_rs1", 32'(bus.o_rs1), 32'd1);
        chk("t3_rs2", 32'(bus.o_rs2), 32'd2);
        chk("t3_funct3", 32'(bus.o_funct3), 32'd0);
        chk("t3_imm", bus.o_imm, 32'hFFFF_FFF8);

        for (int i = 0; i < 3; i++) begin
            cycle($urandom & 32'hFFFF_FFFE, $urandom, 1'($urandom), 1, 1'($urandom));
            chk("t4_hold_pc", bus.o_pc, 32'h104);
            chk("t4_hold_instr", bus.o_instr, 32'hFE20_8CE3);
        end
        cycle(32'h200, 32'h0050_0093, 1, 0, 0);
        chk("t4_resume_pc", bus.o_pc, 32'h200);

        cycle(32'h300, 32'h0000_0013, 1, 0, 1);
        chk("t5_flush_en", 32'(bus.o_clk_en), 32'd0);
        chk("t5_flush_pc", bus.o_pc, 32'h200);
        cycle(32'h304, 32'h0000_0013, 1, 0, 0);
        cycle(32'h308, 32'h0000_0013, 0, 1, 1);
        chk("t5_stall_flush_en", 32'(bus.o_clk_en), 32'd1);
        chk("t5_stall_flush_pc", bus.o_pc, 32'h304);

        cycle(32'h400, 32'h0000_0000, 1, 0, 0);
        chk("t6_zero_ill", 32'(bus.o_illegal), 32'd1);
        chk("t6_zero_en", 32'(bus.o_clk_en), 32'd1);
        chk("t6_zero_pc_next", bus.o_pc_next, 32'h402);
        cycle(32'h404, 32'hFFFF_FFFF, 1, 0, 0);
        chk("t6_ones_ill", 32'(bus.o_illegal), 32'd1);
        chk("t6_ones_en", 32'(bus.o_clk_en), 32'd1);
        chk("t6_ones_imm", bus.o_imm, 32'd0);

        cycle(32'h500, 32'h0000_6105, 1, 0, 0);
        chk("clui_rd2_ill", 32'(bus.o_illegal), 32'd1);
        chk("clui_rd2_instr", bus.o_instr, 32'd0);
        cycle(32'h502, 32'h0000_8002, 1, 0, 0);
        chk("cjr_x0_ill", 32'(bus.o_illegal), 32'd1);
        cycle(32'hFFFF_FFFC, 32'h0050_0093, 1, 0, 0);
        chk("wrap_pc_next", bus.o_pc_next, 32'h0);
        cycle(32'hFFFF_FFFE, 32'h0000_450D, 1, 0, 0);
        chk("wrap_c_pc_next", bus.o_pc_next, 32'h0);

        async_reset();

        for (int k = 0; k < 600; k++) begin
            w  = gen_word();
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            cycle($urandom & 32'hFFFF_FFFE, w, en, st, fl);
            if (k == 300) async_reset();
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
